// File: rtl/note_decoder_sustain.sv
// Key index -> registered one-hot note select with last-key retrigger, release hold and on/off pulses.
// Latency: one cycle from sampled inputs to out/active/note_on/note_off.
// Backpressure: none; a new key index is accepted every cycle while enable is high.
module note_decoder_sustain #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SEL_W-1:0]      in,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      sustain_len,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  active,
  output logic                  note_on,
  output logic                  note_off
);

  localparam int OUT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               active_q, active_d;
  logic               note_on_q, note_on_d;
  logic               note_off_q, note_off_d;

  // State register plus all registered outputs; reset silences everything without a note_off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      active_q   <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      active_q   <= active_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
    end
  end

  // Next state, latched key, release countdown and pulse generation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = PLAY;
          idx_d     = in;
          note_on_d = 1'b1;
        end
      end

      PLAY: begin
        if (enable) begin
          // Last key wins: switch note in place, out never passes through zero.
          if (in != idx_q) begin
            idx_d     = in;
            note_on_d = 1'b1;
          end
        end else if (sustain_len == '0) begin
          state_d    = IDLE;
          note_off_d = 1'b1;
        end else begin
          // Sustain length is captured only here; later changes do not affect this release.
          state_d = RELEASE;
          cnt_d   = sustain_len;
        end
      end

      RELEASE: begin
        if (enable) begin
          // Any press during release retriggers, even the same key.
          state_d   = PLAY;
          idx_d     = in;
          cnt_d     = '0;
          note_on_d = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          // cnt==0 cannot occur here; treating it as expiry keeps the FSM from sticking.
          state_d    = IDLE;
          cnt_d      = '0;
          note_off_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // One-hot decode of the next latched key; zero whenever the next state is silent.
  always_comb begin
    out_d    = '0;
    active_d = (state_d != IDLE);
    if (state_d != IDLE) begin
      out_d[idx_d] = 1'b1;
    end
  end

  assign out      = out_q;
  assign active   = active_q;
  assign note_on  = note_on_q;
  assign note_off = note_off_q;

endmodule

// File: tb/tb_note_decoder_sustain.sv
module tb_note_decoder_sustain;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] in_s = 2'd0;
  logic       enable = 1'b0;
  logic [7:0] len = 8'd0;
  logic [3:0] out_s;
  logic       active;
  logic       note_on;
  logic       note_off;

  int checks = 0;
  int failures = 0;

  note_decoder_sustain #(.SEL_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (in_s),
    .enable     (enable),
    .sustain_len(len),
    .out        (out_s),
    .active     (active),
    .note_on    (note_on),
    .note_off   (note_off)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    in_s    = 2'd0;
    len     = 8'd0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    in_s    = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_s !== 4'b0000 || active !== 1'b0 || note_on !== 1'b0 || note_off !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d out=%b act=%b on=%b off=%b want out=0000 act=0 on=0 off=0",
                 i, out_s, active, note_on, note_off);
      end
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_s !== 4'b0100 || active !== 1'b1 || note_on !== 1'b1 || note_off !== 1'b0) begin
      failures++;
      $display("FAIL reset_release out=%b act=%b on=%b off=%b want out=0100 act=1 on=1 off=0",
               out_s, active, note_on, note_off);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp;
    do_reset();
    len    = 8'd0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_s = k[1:0];
      exp  = 4'b0001 << k;
      tick();
      checks++;
      if (out_s !== exp || note_on !== 1'b1 || active !== 1'b1) begin
        failures++;
        $display("FAIL sweep_first key=%0d out=%b on=%b act=%b want out=%b on=1 act=1",
                 k, out_s, note_on, active, exp);
      end
      tick();
      checks++;
      if (out_s !== exp || note_on !== 1'b0) begin
        failures++;
        $display("FAIL sweep_hold key=%0d out=%b on=%b want out=%b on=0", k, out_s, note_on, exp);
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (out_s !== 4'b0000 || note_off !== 1'b1 || active !== 1'b0 || note_on !== 1'b0) begin
      failures++;
      $display("FAIL sweep_off out=%b off=%b act=%b on=%b want out=0000 off=1 act=0 on=0",
               out_s, note_off, active, note_on);
    end
    tick();
    checks++;
    if (note_off !== 1'b0 || out_s !== 4'b0000) begin
      failures++;
      $display("FAIL sweep_off_pulse off=%b out=%b want off=0 out=0000", note_off, out_s);
    end
  endtask

  task automatic test_sustain();
    do_reset();
    len    = 8'd3;
    enable = 1'b1;
    in_s   = 2'd1;
    tick();
    enable = 1'b0;
    // Edges t, t+1, t+2 hold the note; sustain_len changes after entry are ignored.
    for (int e = 0; e < 3; e++) begin
      tick();
      len = 8'd200;
      checks++;
      if (out_s !== 4'b0010 || active !== 1'b1 || note_off !== 1'b0 || note_on !== 1'b0) begin
        failures++;
        $display("FAIL sustain_hold edge=t+%0d out=%b act=%b off=%b on=%b want out=0010 act=1 off=0 on=0",
                 e, out_s, active, note_off, note_on);
      end
    end
    tick();
    checks++;
    if (out_s !== 4'b0000 || note_off !== 1'b1 || active !== 1'b0) begin
      failures++;
      $display("FAIL sustain_end out=%b off=%b act=%b want out=0000 off=1 act=0", out_s, note_off, active);
    end
    tick();
    checks++;
    if (note_off !== 1'b0) begin
      failures++;
      $display("FAIL sustain_off_pulse off=%b want 0", note_off);
    end
  endtask

  task automatic test_min_sustain();
    do_reset();
    len    = 8'd1;
    enable = 1'b1;
    in_s   = 2'd3;
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (out_s !== 4'b1000 || note_off !== 1'b0) begin
      failures++;
      $display("FAIL len1_hold out=%b off=%b want out=1000 off=0", out_s, note_off);
    end
    tick();
    checks++;
    if (out_s !== 4'b0000 || note_off !== 1'b1) begin
      failures++;
      $display("FAIL len1_end out=%b off=%b want out=0000 off=1", out_s, note_off);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    len    = 8'd5;
    enable = 1'b1;
    in_s   = 2'd3;
    tick();
    enable = 1'b0;
    tick();
    tick();
    checks++;
    if (out_s !== 4'b1000 || note_off !== 1'b0) begin
      failures++;
      $display("FAIL retrig_release out=%b off=%b want out=1000 off=0", out_s, note_off);
    end
    enable = 1'b1;
    in_s   = 2'd0;
    tick();
    checks++;
    if (out_s !== 4'b0001 || note_on !== 1'b1 || active !== 1'b1 || note_off !== 1'b0) begin
      failures++;
      $display("FAIL retrig_new out=%b on=%b act=%b off=%b want out=0001 on=1 act=1 off=0",
               out_s, note_on, active, note_off);
    end
    // Holding the same key must not pulse again: proves the FSM is back in PLAY.
    tick();
    checks++;
    if (out_s !== 4'b0001 || note_on !== 1'b0) begin
      failures++;
      $display("FAIL retrig_play out=%b on=%b want out=0001 on=0", out_s, note_on);
    end
    // Same-key re-press during release also retriggers.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    checks++;
    if (out_s !== 4'b0001 || note_on !== 1'b1) begin
      failures++;
      $display("FAIL retrig_same out=%b on=%b want out=0001 on=1", out_s, note_on);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    len    = 8'd5;
    enable = 1'b1;
    in_s   = 2'd2;
    tick();
    enable = 1'b0;
    tick();
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_s !== 4'b0000 || active !== 1'b0 || note_off !== 1'b0 || note_on !== 1'b0) begin
      failures++;
      $display("FAIL async_clear out=%b act=%b off=%b on=%b want out=0000 act=0 off=0 on=0",
               out_s, active, note_off, note_on);
    end
    #1;
    reset_n = 1'b1;
    tick();
    checks++;
    if (out_s !== 4'b0000 || active !== 1'b0 || note_off !== 1'b0) begin
      failures++;
      $display("FAIL async_after out=%b act=%b off=%b want out=0000 act=0 off=0", out_s, active, note_off);
    end
  endtask

  task automatic test_random();
    int         m_state;
    int         m_idx;
    int         m_cnt;
    logic       m_on;
    logic       m_off;
    logic [3:0] exp_out;
    do_reset();
    m_state = 0;
    m_idx   = 0;
    m_cnt   = 0;
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      in_s   = 2'($urandom_range(0, 3));
      len    = 8'($urandom_range(0, 4));
      m_on   = 1'b0;
      m_off  = 1'b0;
      if (m_state == 0) begin
        if (enable) begin
          m_state = 1; m_idx = int'(in_s); m_on = 1'b1;
        end
      end else if (m_state == 1) begin
        if (enable) begin
          if (int'(in_s) != m_idx) begin
            m_idx = int'(in_s); m_on = 1'b1;
          end
        end else if (len == 8'd0) begin
          m_state = 0; m_off = 1'b1;
        end else begin
          m_state = 2; m_cnt = int'(len);
        end
      end else begin
        if (enable) begin
          m_state = 1; m_idx = int'(in_s); m_cnt = 0; m_on = 1'b1;
        end else if (m_cnt == 1) begin
          m_state = 0; m_off = 1'b1;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      exp_out = (m_state != 0) ? (4'b0001 << m_idx) : 4'b0000;
      tick();
      checks++;
      if (out_s !== exp_out || active !== (m_state != 0) || note_on !== m_on || note_off !== m_off) begin
        failures++;
        $display("FAIL random cyc=%0d out=%b act=%b on=%b off=%b want out=%b act=%0d on=%b off=%b",
                 c, out_s, active, note_on, note_off, exp_out, (m_state != 0), m_on, m_off);
      end
      checks++;
      if ((out_s & (out_s - 4'd1)) !== 4'b0000 || (note_on & note_off) !== 1'b0) begin
        failures++;
        $display("FAIL random_invariant cyc=%0d out=%b on=%b off=%b want onehot-or-zero and exclusive pulses",
                 c, out_s, note_on, note_off);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sustain();
    test_min_sustain();
    test_retrigger();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
